// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
//   Memory-side slave for the CPU data-memory port. It accepts one load or
//   byte-strobed store at a time and returns a single response LATENCY
//   cycles after acceptance. It is backed by a 2**DEPTH_LOG2 x 64-bit array
//   that starts at byte address BASE_ADDR.
//
//   The array is split into eight byte-lane memories. This lets each store
//   strobe map onto its own write enable, and each lane keeps its own
//   registered read port.
//
//   Optional feature: define DMEM_MISALIGN_CHECK_EN to flag misaligned
//   accesses as errors.
//     - Reads: error when req_addr[2:0] != 0.
//     - Writes: error when req_addr[2:0] != 0 and the lane selected by the
//       offset is not strobed.
//   Without the macro, req_addr[2:0] is ignored.
//
// Ports
//   sys_clk    in   clock, rising edge
//   sys_rst    in   asynchronous active-high reset (array contents retained)
//   req_valid  in   request present
//   req_ready  out  high while idle; single outstanding request
//   req_write  in   1 = store, 0 = load
//   req_addr   in   [63:0] byte address
//   req_wdata  in   [63:0] store data, lanes already positioned
//   req_wstrb  in   [7:0] byte enables, bit i -> req_wdata[8i+7:8i]
//   rsp_valid  out  response present
//   rsp_ready  in   requester accepts the response
//   rsp_rdata  out  [63:0] load data (zero for stores and errors)
//   rsp_err    out  access error for this response
// ---------------------------------------------------------------------------
module dmem_responder #(
  parameter int          DEPTH_LOG2 = 12,
  parameter int          LATENCY    = 2,
  parameter logic [63:0] BASE_ADDR  = 64'h0000_0000_8000_0000
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [7:0]  req_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int          DEPTH    = 1 << DEPTH_LOG2;
  // Byte span of the array; an offset at or past this is out of range.
  localparam logic [63:0] SPAN     = 64'd1 << (DEPTH_LOG2 + 3);
  // WAIT lasts LATENCY-1 cycles, so the counter is loaded with LATENCY-2.
  localparam logic [3:0]  CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                  state_reg, state_next;
  logic [3:0]              cnt_reg, cnt_next;
  logic                    write_reg;
  logic                    err_reg;
  logic [DEPTH_LOG2-1:0]   idx_reg;
  logic                    rsp_err_reg;

  // Decode of the request currently on the bus.
  logic [63:0]             offset;
  logic [DEPTH_LOG2-1:0]   req_idx;
  logic                    range_err;
  logic                    misalign;
  logic                    req_err;
  logic                    accept;
  logic                    mem_we;

  // Values used at the edge entering RESP. With LATENCY==1 that edge is the
  // accept edge itself, so the live request is used instead of the latches.
  logic                    cap_write;
  logic                    cap_err;
  logic [DEPTH_LOG2-1:0]   cap_idx;
  logic                    enter_resp;
  logic                    handshake;
  logic                    rd_load;
  logic                    rd_clear;

  assign offset    = req_addr - BASE_ADDR;
  assign req_idx   = offset[DEPTH_LOG2+2:3];
  assign range_err = (req_addr < BASE_ADDR) || (offset >= SPAN);

`ifdef DMEM_MISALIGN_CHECK_EN
  assign misalign  = (req_addr[2:0] != 3'd0) &&
                     (!req_write || !req_wstrb[req_addr[2:0]]);
`else
  assign misalign  = 1'b0;
`endif

  assign req_err   = range_err || misalign;
  assign req_ready = (state_reg == IDLE);
  assign rsp_valid = (state_reg == RESP);
  assign rsp_err   = rsp_err_reg;
  assign accept    = req_valid && req_ready;
  assign mem_we    = accept && req_write && !req_err;

  assign cap_write  = (state_reg == IDLE) ? req_write : write_reg;
  assign cap_err    = (state_reg == IDLE) ? req_err   : err_reg;
  assign cap_idx    = (state_reg == IDLE) ? req_idx   : idx_reg;
  assign enter_resp = (state_reg != RESP) && (state_next == RESP);
  assign handshake  = (state_reg == RESP) && rsp_ready;
  assign rd_load    = enter_resp && !cap_write && !cap_err;
  assign rd_clear   = (enter_resp && (cap_write || cap_err)) || handshake;

  // State register and request latches.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
      write_reg <= 1'b0;
      err_reg   <= 1'b0;
      idx_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (accept) begin
        write_reg <= req_write;
        err_reg   <= req_err;
        idx_reg   <= req_idx;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    unique case (state_reg)
      IDLE: begin
        if (req_valid) begin
          if (LATENCY == 1) begin
            state_next = RESP;
          end else begin
            state_next = WAIT;
            cnt_next   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt_reg == 4'd0) begin
          state_next = RESP;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Response error flag: captured when entering RESP, cleared on handshake.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      rsp_err_reg <= 1'b0;
    end else if (enter_resp) begin
      rsp_err_reg <= cap_err;
    end else if (handshake) begin
      rsp_err_reg <= 1'b0;
    end
  end

  // Byte-lane memories. Only the read-data register is reset; the array
  // itself keeps its contents across reset.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_lane
      logic [7:0] mem [0:DEPTH-1];
      logic [7:0] rdata_reg;

      always_ff @(posedge sys_clk) begin
        if (mem_we && req_wstrb[gi]) begin
          mem[req_idx] <= req_wdata[8*gi +: 8];
        end
      end

      always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
          rdata_reg <= 8'd0;
        end else if (rd_load) begin
          rdata_reg <= mem[cap_idx];
        end else if (rd_clear) begin
          rdata_reg <= 8'd0;
        end
      end

      assign rsp_rdata[8*gi +: 8] = rdata_reg;
    end
  endgenerate

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the CPU data-memory port; it is the slave end of the load/store requests issued by the mem stage.
- Accepts one request at a time (read, or byte-strobed write) on a valid/ready channel.
- Returns a response after a programmable latency on a second valid/ready channel.
- Backs a 64-bit-word internal array and flags out-of-range accesses.

Parameters:
- DEPTH_LOG2, 12, log2 of number of 64-bit words (default 4096 words = 32 KiB).
- LATENCY, 2, cycles from request acceptance to rsp_valid rising; legal range 1..15.
- BASE_ADDR, 64'h0000_0000_8000_0000, byte address of word 0.

Ports:
- sys_clk  input  1  clock, rising edge.
- sys_rst  input  1  reset, asynchronous, active-high.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_write  input  1  1 = store, 0 = load.
- req_addr  input  64  byte address.
- req_wdata  input  64  store data, byte lanes already positioned.
- req_wstrb  input  8  byte enables; bit i enables byte lane i (req_wdata[8i+7:8i]).
- rsp_valid  output  1  response present.
- rsp_ready  input  1  requester accepts the response.
- rsp_rdata  output  64  load data (full word).
- rsp_err  output  1  access error for this response.

Behaviour:
- States: IDLE, WAIT, RESP. A 4-bit down-counter cnt runs during WAIT.
- Reset (asynchronous, active-high):
  - state=IDLE, cnt=0.
  - req_ready=1 once reset is released; rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - Array contents are NOT cleared; they are retained across reset.
- req_ready = (state==IDLE), driven combinationally from state. There is a single outstanding request.
- Accept: req_valid & req_ready at edge T.
  - Latch write flag, word index, and the error flag.
  - Word index = (req_addr - BASE_ADDR) >> 3; bits [2:0] are ignored.
  - Error = (req_addr < BASE_ADDR) or (index >= 2**DEPTH_LOG2). The subtraction is 64-bit unsigned and the comparison uses the full width.
- Write commit happens at edge T, only if there is no error.
  - For each i with req_wstrb[i]=1, byte i of the word is replaced.
  - Write with wstrb=0: no change, normal response.
- Transition at acceptance:
  - If LATENCY==1: go to RESP at edge T; rsp_valid is high in cycle T+1.
  - Otherwise: go to WAIT with cnt=LATENCY-2.
- WAIT: each edge, if cnt==0 go to RESP, else cnt-1. Result: rsp_valid rises exactly LATENCY cycles after the accept edge.
- Read capture happens on the edge entering RESP:
  - Read OK: rsp_rdata = array[index].
  - Error: rsp_rdata = 0.
  - Write: rsp_rdata = 0.
  - rsp_err = latched error flag.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_err hold stable until the handshake.
  - When rsp_ready=1: go to IDLE at that edge, rsp_valid drops next cycle, and rsp_rdata/rsp_err clear to 0.
  - rsp_ready held low: stay in RESP indefinitely.
- No same-cycle turnaround: after the response handshake, req_ready rises the following cycle. Peak throughput is one request per LATENCY+1 cycles.
- req_* inputs are ignored outside IDLE. They are not required to be stable after acceptance.
- Error writes never modify the array.
- Reset mid-operation: the pending response is discarded. A write accepted before reset remains committed.
- rsp_ready asserted while rsp_valid=0: no effect.

Optional Feature:
- Macro: DMEM_MISALIGN_CHECK_EN.
- Defined:
  - An error is also raised when req_addr[2:0]!=0 and wstrb is not contained in the lanes the offset selects.
  - Simplified rule: error if req_addr[2:0]!=0 and req_wstrb[req_addr[2:0]]==0, for writes.
  - Error if req_addr[2:0]!=0, for reads.
  - A misaligned write is not committed.
- Undefined: req_addr[2:0] is ignored entirely, as in the base behaviour.

Test Plan:
- Reset, then write addr=0x8000_0000, wdata=0x1122334455667788, wstrb=0xFF; read the same address -> rsp_rdata=0x1122334455667788, rsp_err=0, rsp_valid exactly 2 cycles after each accept.
- Partial write: to the prior word, wstrb=0x0F, wdata=0xAAAAAAAA_BBBBBBBB; then read -> 0x11223344_BBBBBBBB.
- Out of range: read 0x7FFF_FFF8 and read 0x8000_8000 (DEPTH_LOG2=12) -> rsp_err=1, rsp_rdata=0. Write 0x8000_8000, then read 0x8000_0000 -> word unchanged.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid stays 1, rdata stable, req_ready=0 throughout. Release -> req_ready=1 on the next cycle.
- Reset in WAIT: assert sys_rst one cycle after accepting a write of 0xDEAD to word 3 -> rsp_valid never asserts. After release, a read of word 3 -> 0xDEAD.
- LATENCY=1 and LATENCY=15 builds: back-to-back reads with rsp_ready=1 -> rsp_valid 1 and 15 cycles after accept respectively, req_ready period 2 and 16 cycles.
